// File: rtl/clock_pkg.sv
// Shared definitions for the clock time-setting controller.
// Holds the mode/state encodings and the blink half-period constant.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_SET_HOUR = 2'b01,
        ST_SET_MIN  = 2'b10,
        ST_SET_SEC  = 2'b11
    } state_e;

    // tick_ms strobes per blink half-period (2 Hz blink)
    localparam int unsigned BLINK_HALF_MS = 250;
    localparam int unsigned BLINK_W       = $clog2(BLINK_HALF_MS);

    // Mode key advances RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN
    function automatic state_e next_mode(input state_e s);
        state_e n;
        unique case (s)
            ST_RUN:      n = ST_SET_HOUR;
            ST_SET_HOUR: n = ST_SET_MIN;
            ST_SET_MIN:  n = ST_SET_SEC;
            ST_SET_SEC:  n = ST_RUN;
            default:     n = ST_RUN;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/key_repeat.sv
// Key edge detector with hold/auto-repeat counter.
// o_rise pulses for one cycle on a registered 0->1 of the key level;
// o_press_or_repeat also pulses every HOLD_MS then REPEAT_MS tick_ms
// strobes while the key is held and i_repeat_en is set.
module key_repeat #(
    parameter int unsigned HOLD_MS   = 500,
    parameter int unsigned REPEAT_MS = 200,
    parameter int unsigned MS_W      = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick_ms,
    input  logic i_key,
    input  logic i_repeat_en,
    input  logic i_clr,
    output logic o_rise,
    output logic o_press_or_repeat
);

    logic            r_key;
    logic            r_prev;
    logic            r_repeat;
    logic            w_repeat_d;
    logic [MS_W-1:0] r_ms_cnt;
    logic [MS_W-1:0] w_ms_cnt_d;
    logic [MS_W-1:0] w_ms_inc;
    logic [MS_W-1:0] w_limit;
    logic            w_hold;
    logic            w_hit;

    // Edge registers reset to 1 so a key held through reset yields no edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key  <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_key  <= i_key;
            r_prev <= r_key;
        end
    end

    assign o_rise   = r_key & ~r_prev;
    assign w_hold   = r_key & i_repeat_en;
    assign w_ms_inc = r_ms_cnt + MS_W'(1);
    assign w_limit  = r_repeat ? MS_W'(REPEAT_MS) : MS_W'(HOLD_MS);
    assign w_hit    = w_hold & i_tick_ms & (w_ms_inc == w_limit);

    assign o_press_or_repeat = o_rise | w_hit;

    // Hold counter: reload on each repeat pulse, clear on release or mode change
    always_comb begin
        w_ms_cnt_d = r_ms_cnt;
        w_repeat_d = r_repeat;
        if (!w_hold || i_clr) begin
            w_ms_cnt_d = '0;
            w_repeat_d = 1'b0;
        end else if (i_tick_ms) begin
            if (w_hit) begin
                w_ms_cnt_d = '0;
                w_repeat_d = 1'b1;
            end else begin
                w_ms_cnt_d = w_ms_inc;
            end
        end
    end

    // Hold counter state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ms_cnt <= '0;
            r_repeat <= 1'b0;
        end else begin
            r_ms_cnt <= w_ms_cnt_d;
            r_repeat <= w_repeat_d;
        end
    end

endmodule

// File: rtl/clock_adjust_ctrl.sv
// Time-setting controller for the BCD clock counter chain.
// Mode key walks RUN/SET_HOUR/SET_MIN/SET_SEC; inc key issues one-cycle
// adjust strobes with auto-repeat; idle edit modes time out back to RUN.
// Optional build macro ADJ_BLINK_EN adds the 2 Hz edit-field blink gate.
module clock_adjust_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned HOLD_MS   = 500,
    parameter int unsigned REPEAT_MS = 200,
    parameter int unsigned TIMEOUT_S = 10,
    parameter int unsigned MS_W      = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_ms,
    input  logic       tick_1hz,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic       run_en,
    output logic       inc_hour,
    output logic       inc_min,
    output logic       clr_sec,
    output logic [1:0] mode,
    output logic       blink
);

    localparam int unsigned SEC_W = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S + 1) : 1;

    state_e           r_state;
    state_e           w_state_d;
    logic             r_run_en;
    logic             r_inc_hour;
    logic             r_inc_min;
    logic             r_clr_sec;
    logic             w_inc_hour_d;
    logic             w_inc_min_d;
    logic             w_clr_sec_d;
    logic [SEC_W-1:0] r_sec_cnt;
    logic [SEC_W-1:0] w_sec_cnt_d;
    logic [SEC_W-1:0] w_sec_inc;

    logic w_mode_rise;
    logic w_mode_evt;
    logic w_inc_rise;
    logic w_inc_pulse;
    logic w_key_rise;
    logic w_in_set;
    logic w_repeat_en;
    logic w_timeout;
    logic w_state_change;

    assign w_in_set    = (r_state != ST_RUN);
    assign w_repeat_en = (r_state == ST_SET_HOUR) || (r_state == ST_SET_MIN);
    assign w_key_rise  = w_mode_evt | w_inc_rise;
    assign w_sec_inc   = r_sec_cnt + SEC_W'(1);
    // A key rise in the same cycle as the final second wins over the timeout
    assign w_timeout   = (TIMEOUT_S != 0) && w_in_set && tick_1hz && !w_key_rise &&
                         (w_sec_inc == SEC_W'(TIMEOUT_S));
    assign w_state_change = w_mode_rise | w_timeout;

    key_repeat #(
        .HOLD_MS   (HOLD_MS),
        .REPEAT_MS (REPEAT_MS),
        .MS_W      (MS_W)
    ) u_mode_key (
        .clk               (clk),
        .rst               (rst),
        .i_tick_ms         (tick_ms),
        .i_key             (key_mode),
        .i_repeat_en       (1'b0),
        .i_clr             (1'b0),
        .o_rise            (w_mode_rise),
        .o_press_or_repeat (w_mode_evt)   // repeat disabled: identical to the edge
    );

    key_repeat #(
        .HOLD_MS   (HOLD_MS),
        .REPEAT_MS (REPEAT_MS),
        .MS_W      (MS_W)
    ) u_inc_key (
        .clk               (clk),
        .rst               (rst),
        .i_tick_ms         (tick_ms),
        .i_key             (key_inc),
        .i_repeat_en       (w_repeat_en),
        .i_clr             (w_state_change),
        .o_rise            (w_inc_rise),
        .o_press_or_repeat (w_inc_pulse)
    );

    // Next state and strobes: mode rise > timeout > inc press/repeat
    always_comb begin
        w_state_d    = r_state;
        w_inc_hour_d = 1'b0;
        w_inc_min_d  = 1'b0;
        w_clr_sec_d  = 1'b0;
        if (w_mode_rise) begin
            w_state_d = next_mode(r_state);
        end else if (w_timeout) begin
            w_state_d = ST_RUN;
        end else if (w_inc_pulse) begin
            unique case (r_state)
                ST_SET_HOUR: w_inc_hour_d = 1'b1;
                ST_SET_MIN:  w_inc_min_d  = 1'b1;
                ST_SET_SEC:  w_clr_sec_d  = 1'b1;
                ST_RUN:      ;
            endcase
        end
    end

    // Idle-seconds counter: held at 0 in RUN, restarted by any key rise
    always_comb begin
        w_sec_cnt_d = r_sec_cnt;
        if (!w_in_set || w_key_rise || w_state_change) begin
            w_sec_cnt_d = '0;
        end else if (tick_1hz) begin
            w_sec_cnt_d = w_sec_inc;
        end
    end

    // State, run enable and strobe registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_run_en   <= 1'b1;
            r_inc_hour <= 1'b0;
            r_inc_min  <= 1'b0;
            r_clr_sec  <= 1'b0;
            r_sec_cnt  <= '0;
        end else begin
            r_state    <= w_state_d;
            r_run_en   <= (w_state_d == ST_RUN);
            r_inc_hour <= w_inc_hour_d;
            r_inc_min  <= w_inc_min_d;
            r_clr_sec  <= w_clr_sec_d;
            r_sec_cnt  <= w_sec_cnt_d;
        end
    end

`ifdef ADJ_BLINK_EN
    logic [BLINK_W-1:0] r_blink_cnt;
    logic [BLINK_W-1:0] w_blink_cnt_d;
    logic               r_blink_tgl;
    logic               w_blink_tgl_d;
    logic               r_blink;
    logic               w_blink_d;

    // Half-period divider; blink high means digits shown, forced while inc held
    always_comb begin
        w_blink_cnt_d = r_blink_cnt;
        w_blink_tgl_d = r_blink_tgl;
        if (w_state_d == ST_RUN) begin
            w_blink_cnt_d = '0;
            w_blink_tgl_d = 1'b0;
        end else if (tick_ms) begin
            if (r_blink_cnt == BLINK_W'(BLINK_HALF_MS - 1)) begin
                w_blink_cnt_d = '0;
                w_blink_tgl_d = ~r_blink_tgl;
            end else begin
                w_blink_cnt_d = r_blink_cnt + BLINK_W'(1);
            end
        end
        w_blink_d = (w_state_d != ST_RUN) && (key_inc || !w_blink_tgl_d);
    end

    // Blink divider and gate registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_blink_tgl <= 1'b0;
            r_blink     <= 1'b0;
        end else begin
            r_blink_cnt <= w_blink_cnt_d;
            r_blink_tgl <= w_blink_tgl_d;
            r_blink     <= w_blink_d;
        end
    end

    assign blink = r_blink;
`else
    assign blink = 1'b0;
`endif

    assign run_en   = r_run_en;
    assign inc_hour = r_inc_hour;
    assign inc_min  = r_inc_min;
    assign clr_sec  = r_clr_sec;
    assign mode     = r_state;

endmodule
